mem_io_responder: RTL and testbench

- Memory-side responder on the CPU byte bus (mem_a/mem_dout/mem_wr in, mem_din out, io_buffer_full out).
- Provides byte-wide RAM with 1-cycle read latency and the I/O window at mem_a[17:16]==2'b11.
- I/O window contains:
  - UART TX FIFO (0x30000 write).
  - RX FIFO (0x30000 read).
  - Cycle counter (0x30004 read).
  - Program-stop (0x30004 write).
- Instantiated next to the CPU top in the system wrapper and in simulation benches.

---
 rtl/mem_io_responder.sv | 178 +++++++++++++++++
 tb/tb_mem_io_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
`default_nettype none
// mem_io_responder: CPU-side byte RAM plus I/O window (UART TX/RX FIFOs, cycle counter, program stop).
// Optional MEM_IO_DROP_STAT_EN adds saturating TX/RX drop counters readable at 0x30008/0x30009.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_DEPTH_BIT   = 3,
   parameter int RX_DEPTH_BIT   = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        program_done
);
   localparam int TX_DEPTH = 2 ** TX_DEPTH_BIT;
   localparam int RX_DEPTH = 2 ** RX_DEPTH_BIT;
   localparam logic [TX_DEPTH_BIT:0] TX_FULL_CNT  = (TX_DEPTH_BIT + 1)'(TX_DEPTH);
   localparam logic [TX_DEPTH_BIT:0] TX_NEAR_CNT  = (TX_DEPTH_BIT + 1)'(TX_DEPTH - 1);
   localparam logic [RX_DEPTH_BIT:0] RX_FULL_CNT  = (RX_DEPTH_BIT + 1)'(RX_DEPTH);

   logic [7:0]                ram [2 ** RAM_ADDR_WIDTH];
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic                      io_sel;
   logic [15:0]               io_off;
   logic                      cpu_rd;
   logic                      cpu_wr;
   logic                      unused_addr;

   assign ram_addr    = mem_a[RAM_ADDR_WIDTH-1:0];
   assign io_sel      = (mem_a[17:16] == 2'b11);
   assign io_off      = mem_a[15:0];
   assign cpu_rd      = rdy_in & ~mem_wr;
   assign cpu_wr      = rdy_in & mem_wr;
   assign unused_addr = ^mem_a;

   // ---------------- TX FIFO ----------------
   logic [7:0]              tx_mem [TX_DEPTH];
   logic [TX_DEPTH_BIT-1:0] tx_wr_ptr;
   logic [TX_DEPTH_BIT-1:0] tx_rd_ptr;
   logic [TX_DEPTH_BIT:0]   tx_count;
   logic                    tx_full;
   logic                    tx_pop;
   logic                    tx_push_req;
   logic                    tx_push;
   logic [7:0]              tx_push_data;

   // The stop write forces a 0x00 marker through the FIFO, bypassing the zero filter.
   assign tx_push_req    = cpu_wr & io_sel &
                           (((io_off == 16'h0000) & (mem_dout != 8'h00)) | (io_off == 16'h0004));
   assign tx_push_data   = (io_off == 16'h0004) ? 8'h00 : mem_dout;
   assign tx_full        = (tx_count == TX_FULL_CNT);
   assign tx_valid       = (tx_count != '0);
   assign tx_data        = tx_mem[tx_rd_ptr];
   assign tx_pop         = tx_valid & tx_ready;
   assign tx_push        = tx_push_req & (~tx_full | tx_pop);
   assign io_buffer_full = (tx_count >= TX_NEAR_CNT);

   always_ff @(posedge clk_in) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]              rx_mem [RX_DEPTH];
   logic [RX_DEPTH_BIT-1:0] rx_wr_ptr;
   logic [RX_DEPTH_BIT-1:0] rx_rd_ptr;
   logic [RX_DEPTH_BIT:0]   rx_count;
   logic                    rx_full;
   logic                    rx_pop;
   logic                    rx_push;

   // A pop only happens when a byte is present; on empty the read returns 0 and any same-cycle push stays queued.
   assign rx_full = (rx_count == RX_FULL_CNT);
   assign rx_pop  = cpu_rd & io_sel & (io_off == 16'h0000) & (rx_count != '0);
   assign rx_push = rx_valid & (~rx_full | rx_pop);

   always_ff @(posedge clk_in) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- Counter, snapshot, read path ----------------
   logic [31:0] counter;
   logic [31:0] snapshot;
   logic        stop_pending;
   logic [7:0]  io_rd_data;

`ifdef MEM_IO_DROP_STAT_EN
   logic [7:0] tx_drop;
   logic [7:0] rx_drop;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tx_drop <= 8'h00;
         rx_drop <= 8'h00;
      end else begin
         if (tx_push_req & ~tx_push & (tx_drop != 8'hFF)) tx_drop <= tx_drop + 8'h01;
         if (rx_valid & ~rx_push & (rx_drop != 8'hFF))    rx_drop <= rx_drop + 8'h01;
      end
   end
`endif

   always_comb begin
      io_rd_data = 8'h00;
      case (io_off)
         16'h0000: io_rd_data = (rx_count != '0) ? rx_mem[rx_rd_ptr] : 8'h00;
         16'h0004: io_rd_data = counter[7:0];
         16'h0005: io_rd_data = snapshot[15:8];
         16'h0006: io_rd_data = snapshot[23:16];
         16'h0007: io_rd_data = snapshot[31:24];
`ifdef MEM_IO_DROP_STAT_EN
         16'h0008: io_rd_data = tx_drop;
         16'h0009: io_rd_data = rx_drop;
`endif
         default:  io_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (cpu_wr & ~io_sel) ram[ram_addr] <= mem_dout;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din      <= 8'h00;
         counter      <= 32'h0;
         snapshot     <= 32'h0;
         stop_pending <= 1'b0;
         program_done <= 1'b0;
      end else begin
         if (rdy_in) counter <= counter + 32'd1;
         if (cpu_rd) mem_din <= io_sel ? io_rd_data : ram[ram_addr];
         if (cpu_rd & io_sel & (io_off == 16'h0004)) snapshot <= counter;
         if (cpu_wr & io_sel & (io_off == 16'h0004)) stop_pending <= 1'b1;
         if (stop_pending & (tx_count == '0) & ~tx_valid) program_done <= 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// tb_mem_io_responder: scoreboard bench with a queue-based reference model of the responder.
module tb_mem_io_responder;
   localparam int RAW   = 17;
   localparam int TXD   = 8;
   localparam int RXD   = 8;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic [31:0] mem_a = '0;
   logic [7:0]  mem_dout = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        program_done;

   mem_io_responder #(.RAM_ADDR_WIDTH(RAW), .TX_DEPTH_BIT(3), .RX_DEPTH_BIT(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
      .program_done(program_done)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] ram_m [logic [RAW-1:0]];
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] tx_exp[$];
   int         rd_exp[$];
   logic [31:0] cnt_m, snap_m;
   logic [7:0]  txdrop_m, rxdrop_m;
   bit          stop_m, done_m;

   int          txs0, rxs0;
   bit          txpop, rxpop, txpush, new_done, io;
   logic [7:0]  txb, rxhead;
   logic [15:0] off;
   logic [RAW-1:0] ra;

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tx_q.delete(); rx_q.delete(); tx_exp.delete(); rd_exp.delete();
         cnt_m = 0; snap_m = 0; stop_m = 0; done_m = 0; txdrop_m = 0; rxdrop_m = 0;
      end else begin
         txs0     = tx_q.size();
         rxs0     = rx_q.size();
         txpop    = (txs0 != 0) && tx_ready;
         rxpop    = 0;
         txpush   = 0;
         txb      = 0;
         new_done = done_m | (stop_m && txs0 == 0);
         io       = (mem_a[17:16] == 2'b11);
         off      = mem_a[15:0];
         ra       = mem_a[RAW-1:0];
         if (rdy_in) begin
            if (!io) begin
               if (mem_wr) ram_m[ra] = mem_dout;
               else rd_exp.push_back(ram_m.exists(ra) ? int'(ram_m[ra]) : -1);
            end else if (mem_wr) begin
               if (off == 16'h0000 && mem_dout != 0) begin txpush = 1; txb = mem_dout; end
               else if (off == 16'h0004) begin txpush = 1; txb = 8'h00; stop_m = 1; end
            end else begin
               case (off)
                  16'h0000: if (rxs0 != 0) begin
                                rxhead = rx_q[0]; rd_exp.push_back(int'(rxhead)); rxpop = 1;
                             end else rd_exp.push_back(0);
                  16'h0004: begin rd_exp.push_back(int'(cnt_m[7:0])); snap_m = cnt_m; end
                  16'h0005: rd_exp.push_back(int'(snap_m[15:8]));
                  16'h0006: rd_exp.push_back(int'(snap_m[23:16]));
                  16'h0007: rd_exp.push_back(int'(snap_m[31:24]));
`ifdef MEM_IO_DROP_STAT_EN
                  16'h0008: rd_exp.push_back(int'(txdrop_m));
                  16'h0009: rd_exp.push_back(int'(rxdrop_m));
`endif
                  default:  rd_exp.push_back(0);
               endcase
            end
            cnt_m = cnt_m + 1;
         end
         if (txpop) void'(tx_q.pop_front());
         if (txpush) begin
            if (txs0 < TXD || txpop) begin tx_q.push_back(txb); tx_exp.push_back(txb); end
            else if (txdrop_m != 8'hFF) txdrop_m = txdrop_m + 1;
         end
         if (rxpop) void'(rx_q.pop_front());
         if (rx_valid) begin
            if (rxs0 < RXD || rxpop) rx_q.push_back(rx_data);
            else if (rxdrop_m != 8'hFF) rxdrop_m = rxdrop_m + 1;
         end
         done_m = new_done;
      end
   end

   // ---------------- monitor ----------------
   int         mon_e;
   logic [7:0] mon_b;
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (rd_exp.size() != 0) begin
            mon_e = rd_exp.pop_front();
            if (mon_e >= 0) chk("mem_din", 32'(mem_din), 32'(mon_e[7:0]));
         end
         chk("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
         chk("io_buffer_full", 32'(io_buffer_full), 32'((TXD - tx_q.size()) <= 1));
         chk("program_done", 32'(program_done), 32'(done_m));
         if (tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            else begin
               mon_b = tx_exp.pop_front();
               chk("tx_data", 32'(tx_data), 32'(mon_b));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit r, input logic [31:0] a, input bit w, input logic [7:0] d);
      rdy_in = r; mem_a = a; mem_wr = w; mem_dout = d;
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rdy_in = 0; mem_wr = 0;
      rst_in = 0;
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 32'h0000_0100, 0, 8'h00);
   endtask

   logic [31:0] ra_rand, hi;
   int          kind;

   initial begin
      #20000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("reset_mem_din", 32'(mem_din), 32'h0);
      chk("reset_tx_valid", 32'(tx_valid), 32'h0);
      chk("reset_done", 32'(program_done), 32'h0);

      // RAM write then read-back with one-cycle latency
      step(1, 32'h0000_0010, 1, 8'hA5);
      step(1, 32'h0000_0010, 0, 8'h00);
      chk("ram_readback", 32'(mem_din), 32'hA5);

      // TX fill with no drain: nearly-full after 7, 8th kept, 9th dropped
      tx_ready = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 6) chk("buf_full_at6", 32'(io_buffer_full), 32'h0);
         step(1, 32'h0003_0000, 1, 8'h41);
      end
      chk("buf_full_at7", 32'(io_buffer_full), 32'h1);
      step(1, 32'h0003_0000, 1, 8'h41);
      step(1, 32'h0003_0000, 1, 8'h41);
      tx_ready = 1;
      idle(12);
      chk("tx_drained", 32'(tx_valid), 32'h0);

      // zero filter and stop marker
      tx_ready = 0;
      step(1, 32'h0003_0000, 1, 8'h00);
      chk("zero_filtered", 32'(tx_valid), 32'h0);
      step(1, 32'h0003_0004, 1, 8'h5A);
      chk("stop_marker_valid", 32'(tx_valid), 32'h1);
      chk("stop_marker_data", 32'(tx_data), 32'h00);
      tx_ready = 1;
      idle(3);
      chk("program_done_set", 32'(program_done), 32'h1);
      idle(5);
      chk("program_done_sticky", 32'(program_done), 32'h1);

      // RX: two bytes then three reads
      rx_valid = 1; rx_data = 8'h31; step(0, 32'h0000_0100, 0, 8'h00);
      rx_data = 8'h32;               step(0, 32'h0000_0100, 0, 8'h00);
      rx_valid = 0;
      step(1, 32'h0003_0000, 0, 8'h00); chk("rx_first", 32'(mem_din), 32'h31);
      step(1, 32'h0003_0000, 0, 8'h00); chk("rx_second", 32'(mem_din), 32'h32);
      step(1, 32'h0003_0000, 0, 8'h00); chk("rx_empty", 32'(mem_din), 32'h00);

      // cycle counter and snapshot, with rdy_in freezing
      do_reset();
      idle(32'h1234);
      step(1, 32'h0003_0004, 0, 8'h00); chk("cnt_b0", 32'(mem_din), 32'h34);
      for (int i = 0; i < 5; i++) step(0, 32'h0003_0004, 0, 8'h00);
      step(1, 32'h0003_0005, 0, 8'h00); chk("cnt_b1", 32'(mem_din), 32'h12);
      step(1, 32'h0003_0006, 0, 8'h00); chk("cnt_b2", 32'(mem_din), 32'h00);
      step(1, 32'hFFFF_0007, 0, 8'h00); chk("cnt_b3", 32'(mem_din), 32'h00);
      step(1, 32'h0003_0004, 0, 8'h00); chk("cnt_frozen", 32'(mem_din), 32'h38);

      // async reset with TX busy and stop pending
      step(1, 32'h0000_0020, 1, 8'h77);
      tx_ready = 0;
      step(1, 32'h0003_0000, 1, 8'h11);
      step(1, 32'h0003_0000, 1, 8'h22);
      step(1, 32'h0003_0004, 1, 8'h01);
      #2 rst_in = 0;
      #1;
      chk("async_tx_valid", 32'(tx_valid), 32'h0);
      chk("async_done", 32'(program_done), 32'h0);
      chk("async_mem_din", 32'(mem_din), 32'h0);
      chk("async_buf_full", 32'(io_buffer_full), 32'h0);
      @(posedge clk_in); #1;
      rdy_in = 0;
      @(posedge clk_in); #1;
      rst_in = 1;
      step(1, 32'h0003_0004, 0, 8'h00); chk("cnt_after_reset", 32'(mem_din), 32'h00);
      step(1, 32'h0000_0020, 0, 8'h00); chk("ram_survives_reset", 32'(mem_din), 32'h77);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         tx_ready = ($urandom_range(0, 2) != 0);
         rx_valid = ($urandom_range(0, 2) == 0);
         rx_data  = 8'($urandom);
         hi       = $urandom & 32'hFFFC_0000;
         kind     = $urandom_range(0, 9);
         case (kind)
            0, 1, 2, 3: ra_rand = hi | (32'($urandom_range(0, 2)) << 16) | 32'($urandom_range(0, 31));
            4, 5:       ra_rand = hi | 32'h0003_0000;
            6:          ra_rand = hi | 32'h0003_0004 | 32'($urandom_range(0, 3));
            7:          ra_rand = hi | 32'h0003_0008 | 32'($urandom_range(0, 1));
            default:    ra_rand = hi | 32'h0003_000C;
         endcase
         step(($urandom_range(0, 3) != 0), ra_rand, ($urandom_range(0, 1) == 1), 8'($urandom));
      end
      tx_ready = 1; rx_valid = 0;
      for (int i = 0; i < 20; i++) step(0, 32'h0000_0100, 0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
